// File: rtl/seq_det_pkg.sv
// rtl/seq_det_pkg.sv - state encoding and parameter limits shared by the seq_detect_param slice
package seq_det_pkg;

  // Scan FSM states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Plain-vector encodings of the same states, so state registers stay simple logic vectors.
  localparam logic [1:0] ST_IDLE  = 2'(IDLE);
  localparam logic [1:0] ST_SHIFT = 2'(SHIFT);
  localparam logic [1:0] ST_DONE  = 2'(DONE);

  // Supported parameter range.
  localparam int DATA_W_MIN = 2;
  localparam int DATA_W_MAX = 64;
  localparam int PAT_W_MIN  = 1;

  function automatic bit params_ok(input int data_w, input int pat_w);
    return (data_w >= DATA_W_MIN) && (data_w <= DATA_W_MAX) &&
           (pat_w >= PAT_W_MIN) && (pat_w <= data_w);
  endfunction

endpackage

// File: rtl/seq_det_shreg.sv
// rtl/seq_det_shreg.sv - loadable parallel-in serial-out shift register, MSB first, zero fill
module seq_det_shreg
  import seq_det_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_load,
  input  logic              i_shift,
  input  logic [DATA_W-1:0] i_din,
  output logic              o_msb
);

  logic [DATA_W-1:0] r_sr;

  // Load has priority over shift; shifting pulls zeros in from the LSB side.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_sr <= '0;
    end else if (i_load) begin
      r_sr <= i_din;
    end else if (i_shift) begin
      r_sr <= {r_sr[DATA_W-2:0], 1'b0};
    end
  end

  assign o_msb = r_sr[DATA_W-1];

endmodule

// File: rtl/seq_detect_param.sv
// rtl/seq_detect_param.sv - serial pattern detector over a loaded word; SEQ_DET_RESTART_EN allows reload mid-scan
module seq_detect_param
  import seq_det_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int PAT_W  = 4,
  parameter int CNT_W  = $clog2(DATA_W + 1)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_set,
  input  logic [DATA_W-1:0] i_data,
  input  logic [PAT_W-1:0]  i_pat,
  input  logic              i_overlap,
  output logic              o_z,
  output logic              o_now,
  output logic              o_busy,
  output logic              o_done,
  output logic [CNT_W-1:0]  o_match_cnt
);

  localparam int FILL_W = $clog2(PAT_W + 1);
  localparam int BIT_W  = $clog2(DATA_W + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_W - 1);

  if (!params_ok(DATA_W, PAT_W)) begin : g_param_err
    $error("seq_detect_param: DATA_W/PAT_W outside supported range");
  end

  logic [1:0]        r_state;
  logic [PAT_W-1:0]  r_hist;
  logic [PAT_W-1:0]  r_pat;
  logic              r_ovl;
  logic [FILL_W-1:0] r_fill;
  logic [BIT_W-1:0]  r_bits;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_z;

  logic              w_now;
  logic              w_in_shift;
  logic              w_load;
  logic              w_shift;
  logic [PAT_W-1:0]  w_hist_next;
  logic [FILL_W-1:0] w_fill_inc;
  logic              w_match;

  assign w_in_shift = (r_state == ST_SHIFT);

`ifdef SEQ_DET_RESTART_EN
  // A set during SHIFT throws away the partial scan and starts over.
  assign w_load = i_set && ((r_state == ST_IDLE) || w_in_shift);
`else
  assign w_load = i_set && (r_state == ST_IDLE);
`endif

  assign w_shift = w_in_shift && !w_load;

  // History after this edge: the presented bit enters on the LSB side.
  assign w_hist_next = PAT_W'({r_hist, w_now});
  assign w_fill_inc  = (r_fill == FILL_FULL) ? r_fill : r_fill + 1'b1;
  // Fill saturates at PAT_W, so "full" is the same as fill >= PAT_W.
  assign w_match     = (w_hist_next == r_pat) && (w_fill_inc == FILL_FULL);

  seq_det_shreg #(
    .DATA_W (DATA_W)
  ) u_shreg (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_load  (w_load),
    .i_shift (w_shift),
    .i_din   (i_data),
    .o_msb   (w_now)
  );

  // Scan FSM with history, fill, bit counter, match counter and registered match pulse.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state <= ST_IDLE;
      r_hist  <= '0;
      r_pat   <= '0;
      r_ovl   <= 1'b0;
      r_fill  <= '0;
      r_bits  <= '0;
      r_cnt   <= '0;
      r_z     <= 1'b0;
    end else if (w_load) begin
      r_state <= ST_SHIFT;
      r_pat   <= i_pat;
      r_ovl   <= i_overlap;
      r_hist  <= '0;
      r_fill  <= '0;
      r_bits  <= '0;
      r_cnt   <= '0;
      r_z     <= 1'b0;
    end else begin
      r_z <= 1'b0;
      case (r_state)
        ST_SHIFT: begin
          r_hist <= w_hist_next;
          r_bits <= r_bits + 1'b1;
          r_fill <= (w_match && !r_ovl) ? '0 : w_fill_inc;
          r_z    <= w_match;
          if (w_match) begin
            r_cnt <= r_cnt + 1'b1;
          end
          if (r_bits == BIT_LAST) begin
            r_state <= ST_DONE;
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_z         = r_z;
  assign o_now       = w_now;
  assign o_busy      = w_in_shift;
  assign o_done      = (r_state == ST_DONE);
  assign o_match_cnt = r_cnt;

endmodule

// File: tb/tb_seq_detect_param.sv
// tb/tb_seq_detect_param.sv - directed scoreboard bench for seq_detect_param (PAT_W=4 and PAT_W=3 instances)
module tb_seq_detect_param;

  localparam int DW = 8;
  localparam int CW = $clog2(DW + 1);

`ifdef SEQ_DET_RESTART_EN
  localparam int S6_CNT  = 1;
  localparam int S7_BUSY = 9;
`else
  localparam int S6_CNT  = 2;
  localparam int S7_BUSY = 8;
`endif

  logic          clk     = 1'b0;
  logic          rst_n   = 1'b1;
  logic          set     = 1'b0;
  logic          overlap = 1'b0;
  logic [DW-1:0] data    = '0;
  logic [3:0]    pat4    = '0;
  logic [2:0]    pat3    = '0;

  logic          z4, now4, busy4, done4;
  logic [CW-1:0] cnt4;
  logic          z3, now3, busy3, done3;
  logic [CW-1:0] cnt3;

  typedef struct packed {
    logic z;
    logic now;
    logic busy;
    logic done;
  } obs_t;

  obs_t sb_q[$];
  int   cnt_q[$];
  int   n_checks  = 0;
  int   n_fail    = 0;
  int   sel       = 4;
  int   cyc       = 0;
  int   busy_seen = 0;
  int   last_done = -1;

  seq_detect_param #(.DATA_W(DW), .PAT_W(4)) u_dut4 (
    .i_clk(clk), .i_rst(rst_n), .i_set(set), .i_data(data), .i_pat(pat4),
    .i_overlap(overlap), .o_z(z4), .o_now(now4), .o_busy(busy4), .o_done(done4),
    .o_match_cnt(cnt4)
  );

  seq_detect_param #(.DATA_W(DW), .PAT_W(3)) u_dut3 (
    .i_clk(clk), .i_rst(rst_n), .i_set(set), .i_data(data), .i_pat(pat3),
    .i_overlap(overlap), .o_z(z3), .o_now(now3), .o_busy(busy3), .o_done(done3),
    .o_match_cnt(cnt3)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic obs_t mk(input logic z, input logic n, input logic b, input logic d);
    obs_t o;
    o.z = z; o.now = n; o.busy = b; o.done = d;
    return o;
  endfunction

  function automatic obs_t cur_obs();
    if (sel == 3) return mk(z3, now3, busy3, done3);
    return mk(z4, now4, busy4, done4);
  endfunction

  function automatic int cur_cnt();
    return (sel == 3) ? int'(cnt3) : int'(cnt4);
  endfunction

  // Expected per-cycle outputs of one scan, starting the cycle after set is accepted.
  task automatic push_scan(input logic [DW-1:0] d, input logic [3:0] p, input int pw,
                           input logic ov);
    logic [3:0] mask, hist;
    logic       b, m_prev;
    int         fill, n;
    mask = 4'((1 << pw) - 1);
    hist = '0; fill = 0; n = 0; m_prev = 1'b0;
    for (int k = 1; k <= DW; k++) begin
      b = d[DW-k];
      sb_q.push_back(mk(m_prev, b, 1'b1, 1'b0));
      hist   = ((hist << 1) | {3'b000, b}) & mask;
      fill   = (fill < pw) ? fill + 1 : fill;
      m_prev = (fill >= pw) && (hist == (p & mask));
      if (m_prev) begin
        n++;
        if (!ov) fill = 0;
      end
    end
    sb_q.push_back(mk(m_prev, 1'b0, 1'b0, 1'b1));
    sb_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0));
    cnt_q.push_back(n);
  endtask

  task automatic step();
    obs_t e, o;
    @(posedge clk);
    #1;
    cyc++;
    o = cur_obs();
    if (o.busy) busy_seen++;
    if (o.done) last_done = cyc;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check($sformatf("z@%0d", cyc),    32'(o.z),    32'(e.z));
      check($sformatf("now@%0d", cyc),  32'(o.now),  32'(e.now));
      check($sformatf("busy@%0d", cyc), 32'(o.busy), 32'(e.busy));
      check($sformatf("done@%0d", cyc), 32'(o.done), 32'(e.done));
    end
  endtask

  task automatic drain_to(input int left);
    while (sb_q.size() > left) step();
  endtask

  task automatic start_scan(input logic [DW-1:0] d, input logic [3:0] p, input int pw,
                            input logic ov);
    data = d; pat4 = p; pat3 = p[2:0]; overlap = ov;
    set = 1'b1;
    push_scan(d, p, pw, ov);
    step();
    set = 1'b0;
  endtask

  task automatic check_cnt(input string tag, input int lit);
    int e;
    e = (cnt_q.size() > 0) ? cnt_q.pop_front() : -1;
    check({tag, "_model"}, 32'(cur_cnt()), 32'(e));
    check({tag, "_spec"},  32'(cur_cnt()), 32'(lit));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_z4"},   32'(z4),    32'd0);
    check({tag, "_now4"}, 32'(now4),  32'd0);
    check({tag, "_bsy4"}, 32'(busy4), 32'd0);
    check({tag, "_dn4"},  32'(done4), 32'd0);
    check({tag, "_cnt4"}, 32'(cnt4),  32'd0);
    check({tag, "_bsy3"}, 32'(busy3), 32'd0);
    check({tag, "_now3"}, 32'(now3),  32'd0);
    check({tag, "_cnt3"}, 32'(cnt3),  32'd0);
  endtask

  initial begin
    int s;

    // Power-on reset, checked before any clock edge.
    #1 rst_n = 1'b0;
    #1 check_all_zero("rst0");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    step();

    // Overlapping 1011 in 1011_1011: matches at bits 4 and 8, last z with done.
    sel = 4;
    start_scan(8'b1011_1011, 4'b1011, 4, 1'b1);
    drain_to(0);
    check_cnt("s1_cnt", 2);

    // Pattern 101 on 1010_1010, overlapping then non-overlapping.
    sel = 3;
    start_scan(8'b1010_1010, 4'b0101, 3, 1'b1);
    drain_to(0);
    check_cnt("s2_cnt", 3);
    start_scan(8'b1010_1010, 4'b0101, 3, 1'b0);
    drain_to(0);
    check_cnt("s3_cnt", 2);

    // All-zero word: no match, done exactly 9 cycles after acceptance.
    sel = 4;
    s = cyc;
    start_scan(8'h00, 4'b1011, 4, 1'b1);
    drain_to(0);
    check_cnt("s4_cnt", 0);
    check("s4_done_lat", 32'(last_done - s), 32'd9);

    // Reset mid-scan after bit 5, then a fresh scan.
    start_scan(8'b1011_1011, 4'b1011, 4, 1'b1);
    repeat (5) step();
    #2 rst_n = 1'b0;
    #1 check_all_zero("rst_mid");
    sb_q.delete();
    cnt_q.delete();
    repeat (2) @(posedge clk);
    #1 check_all_zero("rst_hold");
    rst_n = 1'b1;
    start_scan(8'b0011_0110, 4'b0110, 4, 1'b1);
    drain_to(0);
    check_cnt("s5_cnt", 2);

    // Set reasserted while bit 3 is presented.
    start_scan(8'b1011_1011, 4'b1011, 4, 1'b1);
    step();
    step();
    data = 8'b1111_1011;
    set  = 1'b1;
`ifdef SEQ_DET_RESTART_EN
    sb_q.delete();
    cnt_q.delete();
    push_scan(8'b1111_1011, 4'b1011, 4, 1'b1);
`endif
    step();
    set = 1'b0;
    drain_to(0);
    check_cnt("s6_cnt", S6_CNT);

    // Set held two cycles from IDLE, then set asserted during DONE.
    busy_seen = 0;
    data = 8'b1011_1011; pat4 = 4'b1011; overlap = 1'b1;
    set = 1'b1;
    push_scan(8'b1011_1011, 4'b1011, 4, 1'b1);
    step();
`ifdef SEQ_DET_RESTART_EN
    sb_q.delete();
    cnt_q.delete();
    push_scan(8'b1011_1011, 4'b1011, 4, 1'b1);
`endif
    step();
    set = 1'b0;
    drain_to(1);
    check("s7_in_done", 32'(done4), 32'd1);
    set = 1'b1;
    step();
    set = 1'b0;
    sb_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0));
    sb_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0));
    drain_to(0);
    check("s7_busy_cycles", 32'(busy_seen), 32'(S7_BUSY));
    check_cnt("s7_cnt_hold", 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
